// File: rtl/vga_grab_pkg.sv
// Shared types and register map for the VGA frame grabber.
// Holds the capture FSM state encoding, Avalon word addresses and bit positions.
// Imported by the grabber top; carries no logic.
package vga_grab_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Avalon word addresses (only address[1:0] is decoded)
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_PIXCNT = 2'd3;

  // CTRL bit positions
  localparam int CTRL_ARM     = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_DEC_LSB = 2;
  localparam int CTRL_IRQ_EN  = 4;

  // STATUS bit positions
  localparam int STAT_FRAME_DONE = 2;
  localparam int STAT_OVERFLOW   = 3;
  localparam int STAT_UNDERFLOW  = 4;
  localparam int STAT_LEVEL_LSB  = 16;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with synchronous flush.
// Latency: a push is visible on pop_data the cycle after; pop_data always shows the head.
// Backpressure: pushes while full are dropped unless a pop happens in the same cycle.
//
// Ports: clk/reset (sync, active-high), flush clears contents, push/push_data write,
// pop advances the head (ignored when empty), full/empty/level report occupancy.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vga_frame_grabber.sv
// Captures one frame-aligned VGA frame (optionally decimated) into a FIFO drained over Avalon-MM.
// Latency: pixel pushed the cycle it is strobed in CAPTURE; readdata registered, read latency 1.
// Backpressure: none toward the pixel stream; pixels arriving at a full FIFO are dropped and flagged.
//
// Ports: clk/reset (sync, active-high); Avalon slave chipselect/read/write/address/writedata/readdata;
// VGA_R/G/B + pix_valid pixel stream, HSYNC/VSYNC active-low syncs; capturing and irq status outputs.
module vga_frame_grabber
  import vga_grab_pkg::*;
#(
  parameter int PIX_W      = 8,
  parameter int FIFO_DEPTH = 1024,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [7:0]       address,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [PIX_W-1:0] VGA_R,
  input  logic [PIX_W-1:0] VGA_G,
  input  logic [PIX_W-1:0] VGA_B,
  input  logic             pix_valid,
  input  logic             HSYNC,
  input  logic             VSYNC,
  output logic             capturing,
  output logic             irq
);

  state_t            state, state_nxt;
  logic              arm_go, cap_enter, cap_end;
  logic              vs_prev, hs_prev, vs_fall, hs_fall;
  logic [1:0]        dec_reg, dec_act;
  logic              irq_en;
  logic              frame_done, overflow, underflow;
  logic [15:0]       x_cnt, y_cnt, dec_mask;
  logic [31:0]       pix_cnt;
  logic [31:0]       status_word;

  logic              wr_en, rd_en, ctrl_wr, stat_wr, data_rd;
  logic              arm_req, abort_req, flush;
  logic              push_req, push_ok, pop_ok, ovf_evt, udf_evt;
  logic              fifo_full, fifo_empty;
  logic [LVL_W-1:0]  fifo_level;
  logic [23:0]       pix_word, fifo_head;
  logic [PIX_W+7:0]  r_ext, g_ext, b_ext;

  // Bus decode
  assign wr_en     = chipselect & write;
  assign rd_en     = chipselect & read;
  assign ctrl_wr   = wr_en & (address[1:0] == REG_CTRL);
  assign stat_wr   = wr_en & (address[1:0] == REG_STATUS);
  assign data_rd   = rd_en & (address[1:0] == REG_DATA);
  assign arm_req   = ctrl_wr & writedata[CTRL_ARM];
  assign abort_req = ctrl_wr & writedata[CTRL_ABORT];

  // Sync edge detect. prev regs reset low so the first post-reset cycle can never see a fall.
  assign vs_fall = vs_prev & ~VSYNC;
  assign hs_fall = hs_prev & ~HSYNC;

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_prev <= 1'b0;
      hs_prev <= 1'b0;
    end else begin
      vs_prev <= VSYNC;
      hs_prev <= HSYNC;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM next state; abort overrides everything including a simultaneous arm
  always_comb begin
    state_nxt = state;
    arm_go    = 1'b0;
    cap_enter = 1'b0;
    cap_end   = 1'b0;
    if (abort_req) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (arm_req) begin
            state_nxt = ST_WAIT_VS;
            arm_go    = 1'b1;
          end
        end
        ST_WAIT_VS: begin
          if (vs_fall) begin
            state_nxt = ST_CAPTURE;
            cap_enter = 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (vs_fall) begin
            state_nxt = ST_DONE;
            cap_end   = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign flush     = arm_go | abort_req;
  assign capturing = (state == ST_CAPTURE);
  assign irq       = frame_done & irq_en;

  // Control register; the active decimation is only latched by an accepted arm
  always_ff @(posedge clk) begin
    if (reset) begin
      dec_reg <= 2'd0;
      irq_en  <= 1'b0;
      dec_act <= 2'd0;
    end else begin
      if (ctrl_wr) begin
        dec_reg <= writedata[CTRL_DEC_LSB +: 2];
        irq_en  <= writedata[CTRL_IRQ_EN];
      end
      if (arm_go) dec_act <= writedata[CTRL_DEC_LSB +: 2];
    end
  end

  // Pixel position; a line only advances y if it actually carried pixels
  always_ff @(posedge clk) begin
    if (reset || arm_go || cap_enter) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (state == ST_CAPTURE) begin
      if (hs_fall && x_cnt != 16'd0) begin
        x_cnt <= '0;
        y_cnt <= y_cnt + 16'd1;
      end else if (pix_valid) begin
        x_cnt <= x_cnt + 16'd1;
      end
    end
  end

  assign dec_mask = (16'd1 << dec_act) - 16'd1;
  assign push_req = (state == ST_CAPTURE) & pix_valid & ~flush
                  & ((x_cnt & dec_mask) == 16'd0) & ((y_cnt & dec_mask) == 16'd0);
  assign pop_ok   = data_rd & ~fifo_empty;
  assign push_ok  = push_req & (~fifo_full | pop_ok);
  assign ovf_evt  = push_req & fifo_full & ~pop_ok;
  assign udf_evt  = data_rd & fifo_empty;

  // Each channel lands MSB-aligned in its own byte lane, zero-padded below
  assign r_ext    = {VGA_R, 8'd0};
  assign g_ext    = {VGA_G, 8'd0};
  assign b_ext    = {VGA_B, 8'd0};
  assign pix_word = {r_ext[PIX_W+7 -: 8], g_ext[PIX_W+7 -: 8], b_ext[PIX_W+7 -: 8]};

  sync_fifo #(
    .WIDTH (24),
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push_req),
    .push_data (pix_word),
    .pop       (data_rd),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Sticky flags: arm clears all, W1C clears selected, new events win over a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset || arm_go) begin
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (stat_wr) begin
        if (writedata[STAT_FRAME_DONE]) frame_done <= 1'b0;
        if (writedata[STAT_OVERFLOW])   overflow   <= 1'b0;
        if (writedata[STAT_UNDERFLOW])  underflow  <= 1'b0;
      end
      if (cap_end) frame_done <= 1'b1;
      if (ovf_evt) overflow   <= 1'b1;
      if (udf_evt) underflow  <= 1'b1;
    end
  end

  // Accepted-pixel count, saturating
  always_ff @(posedge clk) begin
    if (reset || arm_go)                          pix_cnt <= '0;
    else if (push_ok && pix_cnt != 32'hFFFF_FFFF) pix_cnt <= pix_cnt + 32'd1;
  end

  always_comb begin
    status_word                            = '0;
    status_word[1:0]                       = state;
    status_word[STAT_FRAME_DONE]           = frame_done;
    status_word[STAT_OVERFLOW]             = overflow;
    status_word[STAT_UNDERFLOW]            = underflow;
    status_word[STAT_LEVEL_LSB +: LVL_W]   = fifo_level;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else if (rd_en) begin
      case (address[1:0])
        REG_CTRL:   readdata <= {27'd0, irq_en, dec_reg, 2'b00};
        REG_STATUS: readdata <= status_word;
        REG_DATA:   readdata <= fifo_empty ? 32'd0 : {fifo_head, 8'h00};
        default:    readdata <= pix_cnt;
      endcase
    end else begin
      readdata <= '0;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{address[7:2], writedata[31:5], r_ext[PIX_W-1:0], g_ext[PIX_W-1:0], b_ext[PIX_W-1:0]};

endmodule

// File: doc/vga_frame_grabber.md
Name: vga_frame_grabber

Overview:
- Captures one complete VGA frame from the RGB/sync stream into an internal FIFO.
- Software drains the FIFO over the Avalon-MM slave.
- Successor to the single-pixel snoop reader. Adds:
  - arm/abort control
  - frame-aligned start and stop
  - power-of-two decimation
  - FIFO buffering
  - sticky status flags and a frame-done interrupt
- Sits between the VGA timing/pixel path and the HPS lightweight bridge.

Parameters:
- PIX_W, 8, bits per colour channel (1..10).
- FIFO_DEPTH, 1024, pixel entries. Power of two, ≥4.
- LVL_W, $clog2(FIFO_DEPTH)+1, width of the FIFO fill-level field.

Ports:
- clk  in  1  system clock. VGA inputs are already synchronous to clk.
- reset  in  1  synchronous, active-high.
- chipselect  in  1  Avalon slave select.
- read  in  1  Avalon read strobe.
- write  in  1  Avalon write strobe.
- address  in  8  word address. Only [1:0] are decoded.
- writedata  in  32  write data.
- readdata  out  32  read data, registered, read latency 1.
- VGA_R / VGA_G / VGA_B  in  PIX_W each  pixel colour.
- pix_valid  in  1  pixel strobe. High for one clk per active-area pixel.
- HSYNC  in  1  horizontal sync, active-low.
- VSYNC  in  1  vertical sync, active-low.
- capturing  out  1  high while in CAPTURE.
- irq  out  1  level interrupt, equal to frame_done & irq_en.

Behaviour:
- Register map:
  - Addr 0 CTRL (W):
    - bit0 arm (pulse)
    - bit1 abort (pulse)
    - bits[3:2] dec (0..3)
    - bit4 irq_en
    - Reads back {27'd0, irq_en, dec, 2'b00}.
  - Addr 1 STATUS (R):
    - [1:0] state
    - bit2 frame_done
    - bit3 overflow
    - bit4 underflow
    - [16+LVL_W-1:16] fifo level
  - Addr 1 (W): write-1-to-clear for bits 2..4.
  - Addr 2 DATA (R): pops the FIFO and returns {R,G,B} MSB-aligned into [31:8], [7:0]=0, zero-extended when PIX_W<8.
    - If FIFO empty: returns 0, sets underflow, no pop.
  - Addr 3 PIXCNT (R): 32-bit count of pixels pushed in the current/last frame.
  - Unmapped addresses: read 0, writes ignored.
- Edge detect: vs_fall and hs_fall are one-cycle pulses from the input registered against its previous value (1 → 0). The first cycle after reset yields no edge.
- FSM states (enum, 2 bits): IDLE=0, WAIT_VS=1, CAPTURE=2, DONE=3.
  - IDLE → WAIT_VS on arm. Arm flushes the FIFO and clears PIXCNT, x_cnt, y_cnt and all sticky flags.
  - WAIT_VS → CAPTURE on vs_fall. Pixels before that edge are never pushed.
  - CAPTURE → DONE on the next vs_fall. Sets frame_done that cycle.
  - DONE → WAIT_VS on arm (re-arm, with flush as above).
  - DONE holds otherwise. The FIFO stays readable.
  - Abort in any state → IDLE and flushes the FIFO. Sticky flags are kept.
  - Arm and abort in the same write: abort wins.
  - Arm while in WAIT_VS or CAPTURE: ignored.
- Counters:
  - x_cnt increments on each pix_valid in CAPTURE.
  - On hs_fall: if x_cnt≠0, then y_cnt++ and x_cnt←0.
  - Both counters clear on entry to CAPTURE.
- Push condition: CAPTURE & pix_valid & (x_cnt mod 2^dec == 0) & (y_cnt mod 2^dec == 0).
  - Example: dec=1 keeps even pixels on even lines.
  - dec is sampled on arm. Changes mid-capture have no effect until the next arm.
- FIFO full at push:
  - Pixel dropped, overflow set, PIXCNT not incremented, capture continues.
  - Push and pop in the same cycle while full: both succeed, level unchanged.
- Push and pop in the same cycle while empty: the pop reads empty (underflow). The pushed pixel remains.
- PIXCNT saturates at 32'hFFFF_FFFF.
- Reset: state IDLE, FIFO empty, all flags/counters 0, dec=0, irq_en=0, readdata=0, capturing=0, irq=0.
  - Reset mid-capture discards everything. No edge is detected on the first post-reset cycle.

Decomposition:
- Package vga_grab_pkg:
  - state_t enum
  - register address constants (REG_CTRL, REG_STATUS, REG_DATA, REG_PIXCNT)
  - STATUS/CTRL bit-position localparams
- Sub-module sync_fifo (params WIDTH, DEPTH):
  - single-clock, show-ahead read
  - ports push/pop/flush/full/empty/level
  - same-cycle push+pop allowed

Test Plan:
- Arm, then 3 synthetic 8×4 frames (R=x, G=y, B=0x5A), dec=0 → capture starts at 2nd vs_fall and ends at 3rd; exactly 32 pixels in order; PIXCNT=32; frame_done=1; irq=1 with irq_en=1.
- dec=1, same 8×4 frame → 8 pixels at (0,0),(2,0),(4,0),(6,0),(0,2)...; PIXCNT=8.
- FIFO_DEPTH=16, 32-pixel frame, no reads → level=16, overflow=1, first 16 pixels retained, PIXCNT=16.
- DATA read on empty FIFO → readdata=0, underflow=1. Write 0x10 to STATUS clears it.
- Abort mid-frame after 10 pushes → state IDLE, level 0, capturing=0. Re-arm then captures a full later frame.
- Reset asserted in CAPTURE with level 5 → next cycle all outputs 0, state IDLE, level 0.
